// File: rtl/multibank_sample_buffer.sv
// N-bank capture buffer: one memory split into NBANKS banks, filled round-robin and
// handed to the consumer in arrival order through a present/release handshake.
module multibank_sample_buffer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned NBANKS = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              arm,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic              frame_start,
  output logic [BANK_W-1:0] frame_bank,
  input  logic              frame_done,
  output logic              filling,
  output logic              overrun,
  output logic [15:0]       overrun_cnt
);

  localparam int unsigned OCC_W = $clog2(NBANKS + 1);
  localparam int unsigned MEM_W = BANK_W + ADDR_W;
  localparam logic [OCC_W-1:0]  OccFull  = OCC_W'(NBANKS);
  localparam logic [BANK_W-1:0] BankLast = BANK_W'(NBANKS - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);

  typedef enum logic {WrIdle, WrFill} wr_state_e;
  typedef enum logic [1:0] {RdEmpty, RdPresent, RdGap} rd_state_e;

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              arm_pend_q, arm_pend_d;
  logic              blocked_q, blocked_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       ovr_cnt_q, ovr_cnt_d;
  logic              frame_start_q, frame_start_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [NBANKS*DEPTH];
  logic [MEM_W-1:0]  wr_idx, rd_idx;
  logic              wr_close, rd_release, wr_en, drop;

  assign wr_en      = (wr_state_q == WrFill) && sample_tick;
  assign wr_close   = wr_en && (wr_addr_q == AddrLast);
  assign rd_release = (rd_state_q == RdPresent) && frame_done;
  assign wr_idx     = {wr_bank_q, wr_addr_q};
  assign rd_idx     = {rd_bank_q, rd_addr};

  // blocked_q covers the single IDLE cycle right after a full buffer frees a bank.
  assign blocked_d  = (wr_state_q == WrIdle) && (occ_q == OccFull);
  assign drop       = sample_tick && (wr_state_q == WrIdle) && !mode &&
                      ((occ_q == OccFull) || blocked_q);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    arm_pend_d = arm_pend_q;
    case (wr_state_q)
      WrIdle: begin
        if (arm) arm_pend_d = 1'b1;
        if ((occ_q < OccFull) && (!mode || arm_pend_q)) begin
          wr_state_d = WrFill;
          arm_pend_d = 1'b0;
        end
      end
      WrFill: begin
        if (sample_tick) begin
          if (wr_addr_q == AddrLast) begin
            wr_addr_d  = '0;
            wr_bank_d  = (wr_bank_q == BankLast) ? '0 : wr_bank_q + 1'b1;
            wr_state_d = WrIdle;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    case (rd_state_q)
      RdEmpty:   if (occ_q != '0) rd_state_d = RdPresent;
      RdPresent: begin
        if (frame_done) begin
          rd_state_d = RdGap;
          rd_bank_d  = (rd_bank_q == BankLast) ? '0 : rd_bank_q + 1'b1;
        end
      end
      RdGap:     rd_state_d = (occ_q != '0) ? RdPresent : RdEmpty;
      default:   rd_state_d = RdEmpty;
    endcase
    frame_start_d = (rd_state_d == RdPresent) && (rd_state_q != RdPresent);
  end

  always_comb begin
    occ_d     = occ_q;
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    case ({wr_close, rd_release})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: ;
    endcase
    if (drop) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q    <= WrIdle;
      rd_state_q    <= RdEmpty;
      wr_bank_q     <= '0;
      wr_addr_q     <= '0;
      rd_bank_q     <= '0;
      occ_q         <= '0;
      arm_pend_q    <= 1'b0;
      blocked_q     <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      rd_bank_q     <= rd_bank_d;
      occ_q         <= occ_d;
      arm_pend_q    <= arm_pend_d;
      blocked_q     <= blocked_d;
      overrun_q     <= overrun_d;
      ovr_cnt_q     <= ovr_cnt_d;
      frame_start_q <= frame_start_d;
      if (rd_state_q == RdPresent) rd_data_q <= mem[rd_idx];
    end
  end

  // Storage has no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= sample_in;
  end

  assign rd_data     = rd_data_q;
  assign frame_valid = (rd_state_q == RdPresent);
  assign frame_start = frame_start_q;
  assign frame_bank  = rd_bank_q;
  assign filling     = (wr_state_q == WrFill);
  assign overrun     = overrun_q;
  assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_multibank_sample_buffer.sv
// Self-checking bench for multibank_sample_buffer (DEPTH=8, NBANKS=2) with random samples
// checked against a queue-based model of banks, frames and dropped ticks.
module tb_multibank_sample_buffer;
  localparam int unsigned DW = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NB = 2;

  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, arm = 1'b0, sample_tick = 1'b0;
  logic frame_done = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [2:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic frame_valid, frame_start, filling, overrun;
  logic [0:0] frame_bank;
  logic [15:0] overrun_cnt;

  always #5 clk = ~clk;

  multibank_sample_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .NBANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .arm(arm), .sample_tick(sample_tick),
    .sample_in(sample_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .frame_start(frame_start), .frame_bank(frame_bank),
    .frame_done(frame_done), .filling(filling), .overrun(overrun),
    .overrun_cnt(overrun_cnt)
  );

  int checks = 0, errors = 0;

  // Reference model: banks as queues of samples, frames handed out first-in first-out.
  logic [DW-1:0] sent[$], fill_q[$], rdy_data[$];
  int rdy_bank[$];
  int m_occ, m_wr_bank, m_cnt;
  bit m_open, m_armed, m_ovf, cur_mode;

  int obs_bank[$], exp_bank[$];
  logic [DW-1:0] obs_data[$], exp_data[$];
  logic [DW-1:0] cap[DEPTH];

  task automatic model_clear();
    sent.delete(); fill_q.delete(); rdy_data.delete(); rdy_bank.delete();
    obs_bank.delete(); exp_bank.delete(); obs_data.delete(); exp_data.delete();
    m_occ = 0; m_wr_bank = 0; m_cnt = 0; m_open = 0; m_armed = 0; m_ovf = 0;
  endtask

  task automatic model_tick(input logic [DW-1:0] v);
    if (m_open) begin
      fill_q.push_back(v);
      if (fill_q.size() == DEPTH) begin
        foreach (fill_q[i]) rdy_data.push_back(fill_q[i]);
        rdy_bank.push_back(m_wr_bank);
        m_wr_bank = (m_wr_bank + 1) % NB;
        m_occ++;
        fill_q.delete();
        m_open = 0;
      end
    end else if (!cur_mode && m_occ == NB) begin
      m_ovf = 1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic model_release();
    if (rdy_bank.size() > 0) begin
      void'(rdy_bank.pop_front());
      repeat (DEPTH) void'(rdy_data.pop_front());
      m_occ--;
    end
  endtask

  task automatic model_open();
    if (!m_open && m_occ < NB && (!cur_mode || m_armed)) begin
      m_open = 1;
      m_armed = 0;
    end
  endtask

  task automatic step(input bit t, input bit a, input bit d);
    logic [DW-1:0] v;
    v = DW'($urandom);
    sample_tick = t; sample_in = v; arm = a; frame_done = d;
    @(posedge clk); #1;
    sample_tick = 0; arm = 0; frame_done = 0;
    if (t) begin sent.push_back(v); model_tick(v); end
    if (a && !m_open) m_armed = 1;
    if (d) model_release();
    model_open();
  endtask

  task automatic do_reset();
    rst_n = 0; sample_tick = 0; arm = 0; frame_done = 0; rd_addr = '0;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    rst_n = 1;
    model_clear();
    model_open();
  endtask

  // Ticks every 4 cycles; each presented frame is swept and, if enabled, released
  // 10 cycles after frame_start. Observations and model snapshots are recorded only.
  task automatic run(input int ncyc, input int nticks, input bit rel_en);
    int sent_n = 0;
    int k = -1;
    bit t, d;
    for (int c = 0; c < ncyc; c++) begin
      t = (c % 4 == 2) && (sent_n < nticks);
      d = rel_en && (k == 9);
      rd_addr = (k >= 0 && k < DEPTH) ? 3'(k) : 3'd0;
      step(t, 1'b0, d);
      if (t) sent_n++;
      if (k >= 0 && k < DEPTH) begin
        cap[k] = rd_data;
        if (k == DEPTH - 1) foreach (cap[i]) obs_data.push_back(cap[i]);
      end
      if (d) k = -1;
      else if (k >= 0) k++;
      if (frame_start) begin
        k = 0;
        obs_bank.push_back(int'(frame_bank));
        if (rdy_bank.size() > 0) begin
          exp_bank.push_back(rdy_bank[0]);
          for (int i = 0; i < DEPTH; i++) exp_data.push_back(rdy_data[i]);
        end else begin
          exp_bank.push_back(-1);
        end
      end
    end
  endtask

  task automatic test_reset();
    mode = 0; cur_mode = 0;
    do_reset(); do_reset();
    checks++; if (frame_valid !== 1'b0) begin errors++;
      $display("FAIL reset frame_valid: got %b want 0", frame_valid); end
    checks++; if (frame_start !== 1'b0) begin errors++;
      $display("FAIL reset frame_start: got %b want 0", frame_start); end
    checks++; if (frame_bank !== 1'b0) begin errors++;
      $display("FAIL reset frame_bank: got %b want 0", frame_bank); end
    checks++; if (filling !== 1'b0) begin errors++;
      $display("FAIL reset filling: got %b want 0", filling); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL reset overrun: got %b want 0", overrun); end
    checks++; if (overrun_cnt !== 16'd0) begin errors++;
      $display("FAIL reset overrun_cnt: got %0d want 0", overrun_cnt); end
    checks++; if (rd_data !== '0) begin errors++;
      $display("FAIL reset rd_data: got %0h want 0", rd_data); end
    release_reset();
    step(0, 0, 0);
    checks++; if (filling !== 1'b1) begin errors++;
      $display("FAIL reset_exit filling: got %b want 1", filling); end
  endtask

  task automatic test_continuous();
    int cb[3] = '{0, 1, 0};
    mode = 0; cur_mode = 0;
    do_reset(); release_reset();
    run(120, 24, 1);
    checks++; if (obs_bank.size() != 3) begin errors++;
      $display("FAIL cont frame_count: got %0d want 3", obs_bank.size()); end
    for (int j = 0; j < obs_bank.size() && j < 3; j++) begin
      checks++; if (obs_bank[j] != cb[j]) begin errors++;
        $display("FAIL cont bank[%0d]: got %0d want %0d", j, obs_bank[j], cb[j]); end
    end
    for (int i = 0; i < obs_data.size() && i < 24; i++) begin
      checks++; if (obs_data[i] !== sent[i]) begin errors++;
        $display("FAIL cont data[%0d]: got %0h want %0h", i, obs_data[i], sent[i]); end
    end
    checks++; if (overrun !== 1'b0 || overrun_cnt !== 16'd0) begin errors++;
      $display("FAIL cont overrun: got %b/%0d want 0/0", overrun, overrun_cnt); end
  endtask

  task automatic test_overrun();
    mode = 0; cur_mode = 0;
    do_reset(); release_reset();
    run(84, 20, 0);
    checks++; if (overrun !== 1'b1) begin errors++;
      $display("FAIL ovr flag: got %b want 1", overrun); end
    checks++; if (overrun_cnt !== 16'(m_cnt) || m_cnt != 4) begin errors++;
      $display("FAIL ovr count: got %0d want %0d", overrun_cnt, m_cnt); end
    checks++; if (frame_valid !== 1'b1 || frame_bank !== 1'b0 || filling !== 1'b0) begin
      errors++;
      $display("FAIL ovr hold: got v=%b b=%b f=%b want 1/0/0", frame_valid, frame_bank,
               filling); end
    step(0, 0, 1);
    checks++; if (frame_valid !== 1'b0) begin errors++;
      $display("FAIL ovr gap: got %b want 0", frame_valid); end
    step(0, 0, 0);
    checks++; if (frame_valid !== 1'b1 || frame_start !== 1'b1 || frame_bank !== 1'b1) begin
      errors++;
      $display("FAIL ovr next: got v=%b s=%b b=%b want 1/1/1", frame_valid, frame_start,
               frame_bank); end
    checks++; if (filling !== 1'b1) begin errors++;
      $display("FAIL ovr resume filling: got %b want 1", filling); end
    step(0, 0, 1);
    obs_bank.delete(); exp_bank.delete(); obs_data.delete(); exp_data.delete();
    run(52, 8, 1);
    checks++; if (obs_bank.size() != 1 || obs_bank[0] != 0) begin errors++;
      $display("FAIL ovr resume bank: got n=%0d want one frame on bank 0", obs_bank.size());
    end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++; if (obs_data[i] !== exp_data[i]) begin errors++;
        $display("FAIL ovr resume data[%0d]: got %0h want %0h", i, obs_data[i], exp_data[i]);
      end
    end
    checks++; if (overrun_cnt !== 16'd4) begin errors++;
      $display("FAIL ovr count_hold: got %0d want 4", overrun_cnt); end
  endtask

  task automatic test_single_shot();
    mode = 1; cur_mode = 1;
    do_reset(); release_reset();
    run(48, 12, 1);
    checks++; if (filling !== 1'b0 || frame_valid !== 1'b0 || overrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ss unarmed: got f=%b v=%b c=%0d want 0/0/0", filling, frame_valid,
               overrun_cnt); end
    step(0, 1, 0);
    step(0, 0, 0);
    checks++; if (filling !== 1'b1) begin errors++;
      $display("FAIL ss armed filling: got %b want 1", filling); end
    run(72, 12, 1);
    checks++; if (obs_bank.size() != 1) begin errors++;
      $display("FAIL ss frame_count: got %0d want 1", obs_bank.size()); end
    for (int i = 0; i < obs_data.size() && i < DEPTH; i++) begin
      checks++; if (obs_data[i] !== sent[12 + i]) begin errors++;
        $display("FAIL ss data[%0d]: got %0h want %0h", i, obs_data[i], sent[12 + i]); end
    end
    checks++; if (filling !== 1'b0 || frame_valid !== 1'b0) begin errors++;
      $display("FAIL ss end: got f=%b v=%b want 0/0", filling, frame_valid); end
    checks++; if (overrun !== 1'b0 || overrun_cnt !== 16'd0) begin errors++;
      $display("FAIL ss overrun: got %b/%0d want 0/0", overrun, overrun_cnt); end
  endtask

  task automatic test_simultaneous();
    mode = 0; cur_mode = 0;
    do_reset(); release_reset();
    run(59, 15, 0);
    repeat (3) step(0, 0, 0);
    step(1, 0, 1);
    checks++; if (frame_valid !== 1'b0 || filling !== 1'b0) begin errors++;
      $display("FAIL sim gap: got v=%b f=%b want 0/0", frame_valid, filling); end
    step(0, 0, 0);
    checks++; if (rdy_bank.size() != 1 || m_occ != 1) begin errors++;
      $display("FAIL sim model_occ: got %0d want 1", m_occ); end
    checks++; if (frame_valid !== 1'b1 || frame_start !== 1'b1 ||
                  int'(frame_bank) != 1) begin errors++;
      $display("FAIL sim present: got v=%b s=%b b=%b want 1/1/1", frame_valid, frame_start,
               frame_bank); end
    checks++; if (filling !== 1'b1) begin errors++;
      $display("FAIL sim refill: got %b want 1", filling); end
  endtask

  task automatic test_read_latency();
    int a;
    for (int i = 0; i < DEPTH + 8; i++) begin
      a = (i < DEPTH) ? i : int'($urandom_range(0, DEPTH - 1));
      rd_addr = 3'(a);
      step(0, 0, 0);
      checks++; if (rdy_data.size() < DEPTH || rd_data !== rdy_data[a]) begin errors++;
        $display("FAIL rdlat addr %0d: got %0h want %0h", a, rd_data,
                 (rdy_data.size() >= DEPTH) ? rdy_data[a] : '0); end
    end
    step(0, 0, 1);
  endtask

  task automatic test_reset_mid_fill();
    run(20, 5, 0);
    do_reset();
    checks++; if (frame_valid !== 1'b0 || frame_start !== 1'b0 || frame_bank !== 1'b0 ||
                  filling !== 1'b0) begin errors++;
      $display("FAIL rstmid ctl: got v=%b s=%b b=%b f=%b want 0/0/0/0", frame_valid,
               frame_start, frame_bank, filling); end
    checks++; if (overrun !== 1'b0 || overrun_cnt !== 16'd0 || rd_data !== '0) begin
      errors++;
      $display("FAIL rstmid data: got o=%b c=%0d r=%0h want 0/0/0", overrun, overrun_cnt,
               rd_data); end
    release_reset();
    run(52, 8, 1);
    checks++; if (obs_bank.size() != 1 || obs_bank[0] != 0) begin errors++;
      $display("FAIL rstmid frame: got n=%0d want one frame on bank 0", obs_bank.size());
    end
    for (int i = 0; i < obs_data.size() && i < DEPTH; i++) begin
      checks++; if (obs_data[i] !== sent[i]) begin errors++;
        $display("FAIL rstmid data[%0d]: got %0h want %0h", i, obs_data[i], sent[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_overrun();
    test_single_shot();
    test_simultaneous();
    test_read_latency();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multibank_sample_buffer.md
# multibank_sample_buffer

Parametrised N-bank capture buffer between the ADC sample path and the frame-based pitch estimator. It replaces the fixed two-RAM ping-pong arrangement with one inferred memory split into `NBANKS` banks of `DEPTH` words. It fills the banks in round-robin order and hands full banks to the consumer in strict arrival order through a present/release handshake. It adds single-shot capture and overrun accounting.

## Interface
- `DATA_W`, 12: sample width.
- `DEPTH`, 2048: words per bank; power of two, ≥ 4; `ADDR_W = $clog2(DEPTH)`.
- `NBANKS`, 2: bank count, 2..8; `BANK_W = max(1, $clog2(NBANKS))`.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mode` in 1: 0 = continuous, 1 = single-shot.
- `arm` in 1: single-shot capture request, one-cycle pulse.
- `sample_tick` in 1: sample strobe, one cycle wide.
- `sample_in` in `DATA_W`: sample, valid when `sample_tick`=1.
- `rd_addr` in `ADDR_W`: read address within the presented bank.
- `rd_data` out `DATA_W`: read data.
- `frame_valid` out 1: a full bank is presented.
- `frame_start` out 1: one-cycle pulse on the first `frame_valid` cycle.
- `frame_bank` out `BANK_W`: index of the presented bank.
- `frame_done` in 1: consumer releases the presented bank.
- `filling` out 1: the writer has a bank open.
- `overrun` out 1: sticky flag, a sample was dropped.
- `overrun_cnt` out 16: dropped-sample count, saturating.

## Operation
- State: `wr_bank`, `wr_addr`, `rd_bank`, and `occ` (0..`NBANKS`), the number of banks that are full or being read.
- Writer FSM states:
  - IDLE: continuous mode goes to FILL when `occ<NBANKS`. Single-shot mode goes to FILL when an arm is pending and `occ<NBANKS`.
  - FILL: on each `sample_tick`, writes `mem[wr_bank][wr_addr]` and increments `wr_addr`. The tick at `wr_addr=DEPTH-1` closes the bank: `wr_addr` returns to 0, `wr_bank` increments mod `NBANKS`, `occ` increments, and the FSM returns to IDLE.
- Arm handling: `arm` sets a pending flag. Entering FILL clears it. `arm` during FILL is ignored.
- `mode` is sampled only in IDLE. A change during FILL takes effect at the next bank boundary.
- Overrun: a `sample_tick` in continuous mode while `occ=NBANKS` drops the sample. It sets `overrun` and increments `overrun_cnt`, which saturates at 0xFFFF.
  - Ticks in IDLE for any other reason (single-shot awaiting arm, or the one-cycle IDLE gap) are discarded and not counted.
  - In continuous mode, the writer reaches FILL the cycle after a bank frees. A tick in that gap is counted as overrun.
- Reader FSM states:
  - EMPTY → PRESENT when `occ>0`.
  - PRESENT: `frame_valid`=1 and `frame_bank=rd_bank`. `frame_done` → GAP, with `rd_bank` incrementing mod `NBANKS` and `occ` decrementing.
  - GAP lasts one cycle with `frame_valid`=0, then goes to PRESENT if `occ>0`, else EMPTY.
- `frame_done` outside PRESENT is ignored.
- Bank close and release in the same cycle leave `occ` unchanged. Both pointers still advance.
- Reads always address `rd_bank`. `rd_data` is unspecified outside PRESENT.
- Reset mid-operation discards all bank contents logically. `occ` and the pending-arm flag return to 0.

## Timing
- Reset values:
  - `frame_valid`, `frame_start`, `frame_bank`, `filling` = 0.
  - `overrun` = 0, `overrun_cnt` = 0.
  - `rd_data` = 0 until the first read.
  - Both FSMs in IDLE/EMPTY; pointers 0.
- A sample is written on the clock edge where `sample_tick`=1.
- A bank closes on the edge of its `DEPTH`-th tick. With the reader in EMPTY, `frame_valid` and `frame_start` rise one cycle later.
- `rd_data` is registered: data for `rd_addr` at edge N appears after edge N.
- `frame_valid` falls the cycle after `frame_done`. Minimum low time is 1 cycle.
- A write and a read may target the same memory in the same cycle. They never target the same bank.
- `filling` equals the writer being in FILL.

## Test plan
Bench parameters: `DEPTH`=8, `NBANKS`=2, ticks every 4 cycles unless stated.
- **Continuous, no overrun.** Stimulus: mode 0, samples 0..23; release each frame 10 cycles after `frame_start`. Required: frames on banks 0,1,0 with contents 0–7, 8–15, 16–23; `overrun`=0.
- **Overrun.** Stimulus: mode 0, never assert `frame_done`, samples 0..19. Required: banks 0 and 1 fill, 4 ticks dropped, `overrun`=1, `overrun_cnt`=4. Then pulse `frame_done`. Required: `frame_bank` goes 1 after the gap, and the writer resumes into bank 0.
- **Single-shot.** Stimulus: mode 1, 12 ticks with no arm, then arm, then 12 ticks. Required: exactly one frame containing the first 8 post-arm samples; `filling` drops; the remaining 4 ticks are not counted; `overrun_cnt`=0.
- **Simultaneous close and release.** Stimulus: time `frame_done` on the edge of bank 1's 8th tick. Required: `occ` stays 1; bank 1 is presented after the 1-cycle gap.
- **Read latency.** Stimulus: sweep `rd_addr` 0..7 during PRESENT. Required: `rd_data` matches the written samples one cycle later.
- **Reset mid-fill.** Stimulus: `rst_n`=0 for 1 cycle after 5 ticks. Required: all outputs at reset values, and the next frame presented is bank 0 with 8 fresh samples.
